apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Round-robin scheduler sharing one APB master among NREQ independent requesters.
- Accepts one request at a time and drives the master's transaction inputs (transaction strobe, slave address, RW, write data).
- Watches the APB bus for completion, then returns read data and error to the winning requester.
- Includes a watchdog that aborts a transfer if the slave never completes.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WDATA, 8: data width.
- WADDR, 8: address width.
- TIMEOUT, 16: max cycles in WAIT before abort (≥2).
- GW, $clog2(NREQ): grant-index width (localparam).

Ports:
- i_PCLK  in  1  clock; all logic on rising edge.
- i_PRESET  in  1  reset, synchronous, active-high. Integration feeds the master/slave i_PRESETn from its inverse.
- i_REQ_VALID  in  NREQ  per-requester request valid.
- i_REQ_ADDR  in  NREQ*WADDR  flattened addresses; requester k at [k*WADDR +: WADDR].
- i_REQ_RW  in  NREQ  1=write, 0=read.
- i_REQ_WDATA  in  NREQ*WDATA  flattened write data.
- o_REQ_READY  out  NREQ  one-hot accept pulse.
- o_RSP_VALID  out  NREQ  one-hot response pulse.
- o_RSP_RDATA  out  WDATA  read data (shared by all requesters).
- o_RSP_ERR  out  1  PSLVERR or timeout.
- o_RSP_TIMEOUT  out  1  error was caused by watchdog.
- o_TRANSACTION  out  1  to master i_TRANSACTION.
- o_SLV_ADDR  out  WADDR  to master i_SLV_ADDR.
- o_RW  out  1  to master i_RW.
- o_SLV_WDATA  out  WDATA  to master i_SLV_WDATA.
- i_PSELx, i_PENABLE, i_PREADY  in  1 each  bus monitor.
- i_PRDATA  in  WDATA  bus read data.
- i_PSLVERR  in  1  bus slave error.
- o_BUSY  out  1  high in any state except IDLE.
- o_GRANT_ID  out  GW  index of current or last winner.

Behaviour:
- Reset (synchronous, i_PRESET=1 at a clock edge):
  - State goes to IDLE; every output is 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Watchdog counter = 0.
- Requester rules:
  - Requester holds valid and payload stable until it sees its o_REQ_READY.
  - Dropping valid before ready is legal: the request is simply not accepted.
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE.
  - IDLE:
    - If any valid bit is set, pick the winner: the first set bit searching last+1, last+2, … modulo NREQ.
    - Pulse o_REQ_READY[winner] for one cycle.
    - Latch that requester's addr/rw/wdata into o_SLV_ADDR, o_RW, o_SLV_WDATA.
    - Set o_GRANT_ID = winner; go to ISSUE.
  - ISSUE: o_TRANSACTION=1 for exactly this one cycle; clear the watchdog; go to WAIT.
  - WAIT:
    - o_SLV_ADDR, o_RW, o_SLV_WDATA stay stable.
    - Completion = i_PSELx & i_PENABLE & i_PREADY. On completion: capture i_PRDATA (reads only; writes capture 0) and i_PSLVERR; go to RESP.
    - Otherwise increment the watchdog. When it equals TIMEOUT-1 with no completion: err=1, timeout=1, rdata=0; go to RESP.
    - If completion and watchdog expiry occur in the same cycle, completion wins.
  - RESP:
    - o_RSP_VALID[grant]=1 for exactly one cycle, with o_RSP_RDATA, o_RSP_ERR, o_RSP_TIMEOUT valid in that same cycle.
    - Set last = grant; go to IDLE.
    - Outside RESP, o_RSP_VALID=0; data and err outputs hold their last value.
- Latency and throughput:
  - From acceptance to o_TRANSACTION: 1 cycle.
  - From completion cycle to o_RSP_VALID: 1 cycle.
  - Minimum 4 arbiter cycles per transfer, plus bus cycles.
- New requests arriving in ISSUE/WAIT/RESP are ignored until the next IDLE; no request is ever lost while valid is held.
- Single requester: re-granted every round. All requesters active: strict rotation 0,1,2,3,0…
- Reset mid-transfer: abort immediately with no response pulse; the in-flight requester must re-request.
- o_TRANSACTION is never asserted outside ISSUE.

Test Plan:
- Reset with all valids=1 → all outputs 0; the first IDLE grants requester 0 (o_REQ_READY=4'b0001), and o_TRANSACTION pulses one cycle later.
- Requester 2 write, addr 0x10, wdata 0xA5; slave ready → o_SLV_ADDR=0x10, o_RW=1 held through WAIT; o_RSP_VALID=4'b0100, o_RSP_ERR=0.
- Requester 1 read, addr 0x10 after the write above → o_RSP_VALID=4'b0010, o_RSP_RDATA=0xA5.
- All four valid continuously for 8 transfers → grant order 0,1,2,3,0,1,2,3; each o_REQ_READY and o_RSP_VALID is one-hot.
- Slave drives PSLVERR=1 → o_RSP_ERR=1, o_RSP_TIMEOUT=0. Tie i_PREADY=0 with TIMEOUT=16 → response exactly 16 cycles after ISSUE with err=1, timeout=1, rdata=0.
- Assert i_PRESET in WAIT → next cycle state IDLE, o_BUSY=0, no o_RSP_VALID pulse; the following grant goes to requester 0.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters.
// Each transfer has a watchdog that answers with an error if the slave never completes it.
//   state  | meaning
//   IDLE   | o_REQ_READY pulses for the round-robin winner; its payload is latched
//   ISSUE  | o_TRANSACTION high for one cycle; watchdog cleared
//   WAIT   | wait for PSEL&PENABLE&PREADY or watchdog expiry
//   RESP   | o_RSP_VALID pulse to the winner; rotation pointer advanced
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int WDATA   = 8,
    parameter int WADDR   = 8,
    parameter int TIMEOUT = 16,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   i_PCLK,
    input  logic                   i_PRESET,
    input  logic [NREQ-1:0]        i_REQ_VALID,
    input  logic [NREQ*WADDR-1:0]  i_REQ_ADDR,
    input  logic [NREQ-1:0]        i_REQ_RW,
    input  logic [NREQ*WDATA-1:0]  i_REQ_WDATA,
    output logic [NREQ-1:0]        o_REQ_READY,
    output logic [NREQ-1:0]        o_RSP_VALID,
    output logic [WDATA-1:0]       o_RSP_RDATA,
    output logic                   o_RSP_ERR,
    output logic                   o_RSP_TIMEOUT,
    output logic                   o_TRANSACTION,
    output logic [WADDR-1:0]       o_SLV_ADDR,
    output logic                   o_RW,
    output logic [WDATA-1:0]       o_SLV_WDATA,
    input  logic                   i_PSELx,
    input  logic                   i_PENABLE,
    input  logic                   i_PREADY,
    input  logic [WDATA-1:0]       i_PRDATA,
    input  logic                   i_PSLVERR,
    output logic                   o_BUSY,
    output logic [GW-1:0]          o_GRANT_ID
);

    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_inc;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   scan_idx;
    logic            any_valid;
    logic            complete;

    assign wdog_inc = wdog + 1'b1;
    assign complete = i_PSELx & i_PENABLE & i_PREADY;
    assign o_BUSY   = (state != S_IDLE);

    // Scan from farthest to nearest so the requester closest after 'last' wins.
    always_comb begin
        winner    = last;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            scan_idx = GW'((int'(last) + i) % NREQ);
            if (i_REQ_VALID[scan_idx]) begin
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    // Ready is a same-cycle acknowledge so the payload is latched at the very edge it is granted.
    always_comb begin
        o_REQ_READY = '0;
        if (state == S_IDLE && any_valid && !i_PRESET)
            o_REQ_READY[winner] = 1'b1;
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state         <= S_IDLE;
            last          <= GW'(NREQ - 1);
            wdog          <= '0;
            o_TRANSACTION <= 1'b0;
            o_SLV_ADDR    <= '0;
            o_RW          <= 1'b0;
            o_SLV_WDATA   <= '0;
            o_RSP_VALID   <= '0;
            o_RSP_RDATA   <= '0;
            o_RSP_ERR     <= 1'b0;
            o_RSP_TIMEOUT <= 1'b0;
            o_GRANT_ID    <= '0;
        end else begin
            o_TRANSACTION <= 1'b0;
            o_RSP_VALID   <= '0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        o_SLV_ADDR    <= i_REQ_ADDR[int'(winner)*WADDR +: WADDR];
                        o_RW          <= i_REQ_RW[winner];
                        o_SLV_WDATA   <= i_REQ_WDATA[int'(winner)*WDATA +: WDATA];
                        o_GRANT_ID    <= winner;
                        o_TRANSACTION <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (complete) begin
                        o_RSP_RDATA             <= o_RW ? '0 : i_PRDATA;
                        o_RSP_ERR               <= i_PSLVERR;
                        o_RSP_TIMEOUT           <= 1'b0;
                        o_RSP_VALID[o_GRANT_ID] <= 1'b1;
                        state                   <= S_RESP;
                    end else if (wdog_inc == WW'(TIMEOUT - 1)) begin
                        o_RSP_RDATA             <= '0;
                        o_RSP_ERR               <= 1'b1;
                        o_RSP_TIMEOUT           <= 1'b1;
                        o_RSP_VALID[o_GRANT_ID] <= 1'b1;
                        state                   <= S_RESP;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                S_RESP: begin
                    last  <= o_GRANT_ID;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
